// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one req/ack memory port between the instruction
// refill path and the data-cache refill / single-word write-through path.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BEATS      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_done,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_done,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    localparam int BW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFFW = $clog2(BEATS) + 2;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVE_I    = 2'd1,
        SERVE_D_RD = 2'd2,
        SERVE_D_WR = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } side_t;

    state_t                r_state;
    side_t                 r_last_grant;
    logic [BW-1:0]         r_beat;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_i_rvalid;
    logic                  r_i_done;
    logic [DATA_WIDTH-1:0] r_i_rdata;
    logic                  r_d_rvalid;
    logic                  r_d_done;
    logic [DATA_WIDTH-1:0] r_d_rdata;

    logic                  w_i_req;
    logic                  w_d_req;
    logic                  w_last_beat;
    logic [ADDR_WIDTH-1:0] w_base;
    logic [ADDR_WIDTH-1:0] w_read_addr;
    logic [ADDR_WIDTH-1:0] w_write_addr;
    logic                  w_unused_addr;

    // A side still showing its done pulse may not have dropped req yet; never re-grant it there.
    always_comb begin
        w_i_req     = i_req & ~r_i_done;
        w_d_req     = d_req & ~r_d_done;
        w_last_beat = (r_beat == LAST_BEAT);
    end

    // Beat address generation from the address latched at grant.
    always_comb begin
        w_base        = {r_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
        w_read_addr   = w_base + ADDR_WIDTH'({r_beat, 2'b00});
        w_write_addr  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
        w_unused_addr = ^r_addr[1:0];
    end

    // Memory-side handshake decoded from state and latched transaction fields.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_WIDTH{1'b0}};
        mem_wdata = {DATA_WIDTH{1'b0}};
        case (r_state)
            SERVE_I, SERVE_D_RD: begin
                mem_req  = 1'b1;
                mem_addr = w_read_addr;
            end
            SERVE_D_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = w_write_addr;
                mem_wdata = r_wdata;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
        busy = (r_state != IDLE);
    end

    // Arbitration and burst sequencing FSM with registered requester outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_D;
            r_beat       <= {BW{1'b0}};
            r_addr       <= {ADDR_WIDTH{1'b0}};
            r_wdata      <= {DATA_WIDTH{1'b0}};
            r_i_rvalid   <= 1'b0;
            r_i_done     <= 1'b0;
            r_i_rdata    <= {DATA_WIDTH{1'b0}};
            r_d_rvalid   <= 1'b0;
            r_d_done     <= 1'b0;
            r_d_rdata    <= {DATA_WIDTH{1'b0}};
        end else begin
            r_i_rvalid <= 1'b0;
            r_i_done   <= 1'b0;
            r_i_rdata  <= {DATA_WIDTH{1'b0}};
            r_d_rvalid <= 1'b0;
            r_d_done   <= 1'b0;
            r_d_rdata  <= {DATA_WIDTH{1'b0}};
            case (r_state)
                IDLE: begin
                    r_beat <= {BW{1'b0}};
                    // On contention the side that did not win the previous tie goes first.
                    if (w_i_req && (!w_d_req || (r_last_grant == GRANT_D))) begin
                        r_state <= SERVE_I;
                        r_addr  <= i_addr;
                        if (w_d_req) begin
                            r_last_grant <= GRANT_I;
                        end
                    end else if (w_d_req) begin
                        r_state <= d_we ? SERVE_D_WR : SERVE_D_RD;
                        r_addr  <= d_addr;
                        r_wdata <= d_wdata;
                        if (w_i_req) begin
                            r_last_grant <= GRANT_D;
                        end
                    end
                end
                SERVE_I: begin
                    if (mem_ack) begin
                        r_i_rvalid <= 1'b1;
                        r_i_rdata  <= mem_rdata;
                        r_beat     <= w_last_beat ? {BW{1'b0}} : r_beat + BW'(1);
                        if (w_last_beat) begin
                            r_i_done <= 1'b1;
                            r_state  <= IDLE;
                        end
                    end
                end
                SERVE_D_RD: begin
                    if (mem_ack) begin
                        r_d_rvalid <= 1'b1;
                        r_d_rdata  <= mem_rdata;
                        r_beat     <= w_last_beat ? {BW{1'b0}} : r_beat + BW'(1);
                        if (w_last_beat) begin
                            r_d_done <= 1'b1;
                            r_state  <= IDLE;
                        end
                    end
                end
                SERVE_D_WR: begin
                    if (mem_ack) begin
                        r_d_done <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign i_rvalid = r_i_rvalid;
    assign i_rdata  = r_i_rdata;
    assign i_done   = r_i_done;
    assign d_rvalid = r_d_rvalid;
    assign d_rdata  = r_d_rdata;
    assign d_done   = r_d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// request/ack traffic checked against a transaction-level arbitration model.
module tb_mem_arbiter;

    localparam int BEATS = 4;
    localparam logic [31:0] LINE_MASK = 32'(BEATS * 4 - 1);

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we, mem_ack;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_rvalid, i_done, d_rvalid, d_done;
    logic [31:0] i_rdata, d_rdata;
    logic        mem_req, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata;

    int checks = 0;
    int errors = 0;
    bit model_last_d;

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BEATS(BEATS)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: a tie goes to the side that did not win the previous tie.
    function automatic bit pick_d(input bit ri, input bit rd);
        bit win_d;
        if (ri && rd) begin
            win_d = !model_last_d;
            model_last_d = win_d;
        end else begin
            win_d = rd;
        end
        return win_d;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        model_last_d = 1'b1;
    endtask

    // Serves one granted transaction as the memory; call right after the grant edge.
    task automatic run_txn(input bit side_d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [15:0] pat, input int pat_len,
                           input int ack_pct, input bit drop_early, output int ncyc);
        int beat, nbeats;
        logic ack;
        logic [31:0] exp_addr, rd;
        logic exp_rv, exp_done;
        nbeats = we ? 1 : BEATS;
        beat = 0;
        ncyc = 0;
        while (beat < nbeats) begin
            if (ncyc >= 300) begin
                checks++; errors++;
                $display("FAIL txn_timeout: beat %0d of %0d after %0d cycles, required completion", beat, nbeats, ncyc);
                return;
            end
            exp_addr = we ? (addr & ~32'h3) : ((addr & ~LINE_MASK) + 32'(4 * beat));
            checks++;
            if (mem_req !== 1'b1 || mem_we !== we || mem_addr !== exp_addr || busy !== 1'b1 ||
                (we && mem_wdata !== wdata)) begin
                errors++;
                $display("FAIL mem_beat: req=%b we=%b addr=%h wdata=%h busy=%b, required req=1 we=%b addr=%h wdata=%h busy=1",
                         mem_req, mem_we, mem_addr, mem_wdata, busy, we, exp_addr, wdata);
            end
            ack = (ncyc < pat_len) ? pat[ncyc] : ($urandom_range(99) < 32'(ack_pct));
            rd = $urandom;
            mem_ack = ack;
            mem_rdata = rd;
            tick();
            ncyc++;
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if (ack) beat++;
            exp_rv = ack && !we;
            exp_done = ack && (beat == nbeats);
            checks++;
            if (i_rvalid !== (exp_rv && !side_d) || i_done !== (exp_done && !side_d) ||
                d_rvalid !== (exp_rv && side_d) || d_done !== (exp_done && side_d) ||
                (side_d ? (i_rdata !== 32'h0) : (d_rdata !== 32'h0)) ||
                (exp_rv && ((side_d ? d_rdata : i_rdata) !== rd))) begin
                errors++;
                $display("FAIL req_out: i rv=%b done=%b data=%h d rv=%b done=%b data=%h, required side_d=%b rv=%b done=%b data=%h",
                         i_rvalid, i_done, i_rdata, d_rvalid, d_done, d_rdata, side_d, exp_rv, exp_done, rd);
            end
            // Requester-side inputs wander after grant; the latched copy must be used.
            if (side_d) begin
                d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(1));
            end else begin
                i_addr = $urandom;
            end
            if (drop_early && beat >= 1) begin
                if (side_d) d_req = 1'b0; else i_req = 1'b0;
            end
            if (exp_done) begin
                if (side_d) d_req = 1'b0; else i_req = 1'b0;
                checks++;
                if (mem_req !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL txn_end: mem_req=%b busy=%b, required 0 0", mem_req, busy);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if ({i_rvalid, i_done, d_rvalid, d_done, mem_req, mem_we, busy} !== 7'b0 ||
                i_rdata !== 32'h0 || d_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs: flags=%b mem_addr=%h, required all zero",
                         {i_rvalid, i_done, d_rvalid, d_done, mem_req, mem_we, busy}, mem_addr);
            end
        end
        rst = 1'b0;
        model_last_d = 1'b1;
    endtask

    task automatic test_single_refill();
        int n;
        i_req = 1'b1; i_addr = 32'h0000_1234;
        tick();
        run_txn(1'b0, 1'b0, 32'h0000_1234, 32'h0, 16'hFFFF, 16, 100, 1'b0, n);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL single_cycles: %0d cycles, required 4", n);
        end
    endtask

    task automatic test_tie();
        int n;
        logic [31:0] ia;
        do_reset();
        ia = $urandom;
        i_req = 1'b1; i_addr = ia; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        if (pick_d(1'b1, 1'b1)) begin
            checks++; errors++;
            $display("FAIL model_first_tie: got D, required I");
        end
        tick();
        run_txn(1'b0, 1'b0, ia, 32'h0, 16'h0, 0, 70, 1'b0, n);
        tick();
        run_txn(1'b1, 1'b0, 32'h40, 32'h0, 16'h0, 0, 70, 1'b0, n);
        tick();
        ia = $urandom;
        i_req = 1'b1; i_addr = ia; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        void'(pick_d(1'b1, 1'b1));
        tick();
        run_txn(1'b1, 1'b0, 32'h80, 32'h0, 16'h0, 0, 70, 1'b0, n);
        tick();
        run_txn(1'b0, 1'b0, ia, 32'h0, 16'h0, 0, 70, 1'b0, n);
        tick();
    endtask

    task automatic test_write_stall();
        int n;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0106; d_wdata = 32'hDEAD_BEEF;
        tick();
        run_txn(1'b1, 1'b1, 32'h0000_0106, 32'hDEAD_BEEF, 16'h0008, 4, 100, 1'b0, n);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL write_cycles: %0d cycles, required 4", n);
        end
        tick();
    endtask

    task automatic test_ack_gaps();
        int n;
        logic [31:0] ia;
        ia = $urandom;
        i_req = 1'b1; i_addr = ia;
        tick();
        run_txn(1'b0, 1'b0, ia, 32'h0, 16'h0059, 7, 100, 1'b0, n);
        checks++;
        if (n !== 7) begin
            errors++;
            $display("FAIL gap_cycles: %0d cycles, required 7", n);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        int n;
        logic [31:0] da, base;
        do_reset();
        da = $urandom;
        base = da & ~LINE_MASK;
        d_req = 1'b1; d_we = 1'b0; d_addr = da;
        tick();
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== base + 32'(4 * b)) begin
                errors++;
                $display("FAIL abort_beat: req=%b addr=%h, required 1 %h", mem_req, mem_addr, base + 32'(4 * b));
            end
            mem_ack = 1'b1; mem_rdata = $urandom;
            tick();
            mem_ack = 1'b0;
        end
        checks++;
        if (mem_addr !== base + 32'h8 || d_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_beat2: addr=%h done=%b, required %h 0", mem_addr, d_done, base + 32'h8);
        end
        rst = 1'b1; mem_ack = 1'b1; d_req = 1'b0;
        tick();
        model_last_d = 1'b1;
        checks++;
        if (mem_req !== 1'b0 || d_done !== 1'b0 || d_rvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: req=%b done=%b rvalid=%b busy=%b, required 0 0 0 0", mem_req, d_done, d_rvalid, busy);
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_ack = 1'b1; mem_rdata = $urandom;
            tick();
            checks++;
            if ({i_rvalid, i_done, d_rvalid, d_done, mem_req, busy} !== 6'b0) begin
                errors++;
                $display("FAIL stray_ack: flags=%b, required 000000", {i_rvalid, i_done, d_rvalid, d_done, mem_req, busy});
            end
        end
        mem_ack = 1'b0;
        i_req = 1'b1; i_addr = 32'h0000_2010;
        tick();
        run_txn(1'b0, 1'b0, 32'h0000_2010, 32'h0, 16'h0, 0, 80, 1'b0, n);
        tick();
    endtask

    task automatic test_req_drop();
        int n;
        logic [31:0] da;
        da = $urandom;
        d_req = 1'b1; d_we = 1'b0; d_addr = da;
        tick();
        run_txn(1'b1, 1'b0, da, 32'h0, 16'h0, 0, 60, 1'b1, n);
        tick();
    endtask

    task automatic test_random();
        int n, pct;
        bit ri, rdq, we, first_d;
        logic [31:0] ia, da, dw;
        for (int t = 0; t < 40; t++) begin
            ri = 1'($urandom_range(1));
            rdq = 1'($urandom_range(1));
            if (!ri && !rdq) ri = 1'b1;
            ia = $urandom; da = $urandom; dw = $urandom;
            we = 1'($urandom_range(1));
            pct = $urandom_range(100, 30);
            i_req = ri; i_addr = ia; d_req = rdq; d_addr = da; d_we = we; d_wdata = dw;
            first_d = pick_d(ri, rdq);
            tick();
            if (first_d) run_txn(1'b1, we, da, dw, 16'h0, 0, pct, 1'b0, n);
            else         run_txn(1'b0, 1'b0, ia, 32'h0, 16'h0, 0, pct, 1'b0, n);
            if (ri && rdq) begin
                tick();
                if (first_d) run_txn(1'b0, 1'b0, ia, 32'h0, 16'h0, 0, pct, 1'b0, n);
                else         run_txn(1'b1, we, da, dw, 16'h0, 0, pct, 1'b0, n);
            end
            repeat ($urandom_range(3, 1)) begin
                tick();
                checks++;
                if (busy !== 1'b0 || mem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_gap: busy=%b mem_req=%b, required 0 0", busy, mem_req);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_refill();
        tick();
        test_tie();
        test_write_stall();
        test_ack_gaps();
        test_reset_mid_burst();
        test_req_drop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbitrates a single shared main-memory port between the instruction-side refill path and the data_cache miss/write-through path.
- Instruction side issues line-refill reads.
- Data side issues line-refill reads or single-word write-throughs.
- Requesters are granted round-robin. Each grant is sequenced as a beat-counted burst over a req/ack memory handshake.
- Sits in the Memory/Fetch boundary, below instruction_memory/data_cache and above the backing data_mem.

Parameters:
DATA_WIDTH, 32, width of data words on all ports
ADDR_WIDTH, 32, width of byte addresses on all ports
BEATS, 4, words per line refill; power of two, >=1

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
i_req  input  1  instruction-side refill request, held until i_done
i_addr  input  ADDR_WIDTH  instruction-side miss byte address
i_rvalid  output  1  refill word valid on i_rdata
i_rdata  output  DATA_WIDTH  refill word
i_done  output  1  one-cycle pulse, last refill word delivered
d_req  input  1  data-side request, held until d_done
d_we  input  1  1 = single-word write, 0 = line refill read
d_addr  input  ADDR_WIDTH  data-side byte address
d_wdata  input  DATA_WIDTH  write-through data
d_rvalid  output  1  refill word valid on d_rdata
d_rdata  output  DATA_WIDTH  refill word
d_done  output  1  one-cycle pulse, transaction complete
mem_req  output  1  memory beat request, held until mem_ack
mem_we  output  1  memory write enable
mem_addr  output  ADDR_WIDTH  memory word address (byte units)
mem_wdata  output  DATA_WIDTH  memory write data
mem_ack  input  1  beat accepted / read data valid this cycle
mem_rdata  input  DATA_WIDTH  memory read data, valid with mem_ack
busy  output  1  high in any non-IDLE state

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - State goes to IDLE; beat counter = 0; last_grant = D.
  - All outputs 0.
  - rst mid-burst aborts: mem_req low the next cycle; a late mem_ack is ignored; no done pulse is issued.
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- FSM states: IDLE, SERVE_I, SERVE_D_RD, SERVE_D_WR.
- IDLE arbitration, sampled at the edge:
  - Only i_req -> SERVE_I.
  - Only d_req -> SERVE_D_WR if d_we, else SERVE_D_RD.
  - Both -> grant the side not equal to last_grant, and update last_grant. After reset the I side wins the first contention.
  - Address, we and wdata of the granted requester are latched at grant. Later changes on the request inputs are ignored.
- Read burst (SERVE_I / SERVE_D_RD):
  - base = latched addr with the low log2(BEATS)+2 bits cleared.
  - mem_req=1, mem_we=0, mem_addr = base + 4*beat.
  - Each cycle with mem_ack=1: capture mem_rdata; the beat counter increments and wraps to 0 after BEATS-1.
  - x_rvalid=1 and x_rdata are registered, appearing the cycle after each ack.
  - x_done pulses together with the final x_rvalid.
  - On the last ack: mem_req drops the next cycle and the state returns to IDLE.
- Write (SERVE_D_WR):
  - mem_req=1, mem_we=1, mem_addr = latched d_addr with bits [1:0] cleared, mem_wdata = latched d_wdata.
  - On mem_ack: return to IDLE; d_done pulses the next cycle; d_rvalid stays 0.
- Timing:
  - Minimum latency from req at the IDLE edge to first mem_req = 1 cycle.
  - One IDLE cycle is guaranteed between consecutive transactions.
  - A requester may re-assert req in the cycle after its done pulse.
- mem_ack while in IDLE is ignored. A beat with mem_ack held low stalls indefinitely with mem_req and mem_addr stable.
- Requester dropping req mid-transaction: the transaction still completes and the done pulse is still issued.
- Non-granted side outputs: rvalid, rdata and done stay 0.
- Grant side and burst phase are never combinationally dependent on mem_ack. All outputs are registered except mem_* and busy, which decode from state and latched registers.

Test Plan:
1. Reset, then i_req with i_addr=0x0000_1234, mem_ack=1 every cycle -> mem_addr sequence 0x1230, 0x1234, 0x1238, 0x123C. i_rvalid for 4 cycles with the matching mem_rdata. i_done on the 4th beat; busy drops after.
2. i_req and d_req (d_we=0, d_addr=0x40) asserted together after reset -> I served first. D burst at 0x40..0x4C starts after one IDLE cycle. On the next tie, I re-requests and D is granted first.
3. d_req, d_we=1, d_addr=0x0000_0106, d_wdata=0xDEADBEEF, mem_ack delayed 3 cycles -> mem_req/mem_we held 3 cycles with mem_addr=0x104 and mem_wdata=0xDEADBEEF. d_done one cycle after ack; d_rvalid never 1.
4. Burst with mem_ack gapped (1,0,0,1,1,0,1) -> exactly 4 i_rvalid pulses. mem_addr advances only after each ack.
5. rst asserted during beat 2 of a D read -> mem_req 0 next cycle; no d_done. A stray mem_ack afterward produces no output. A new i_req is served normally.
6. d_addr changed and d_req dropped mid-burst -> burst completes at the originally latched base address and d_done is still pulsed.
